vslc_7seg_scanner: RTL and testbench
====================================

# vslc_7seg_scanner

Two-digit multiplexed seven-segment scanner for the VSLC board build. Sits directly downstream of the VSLC core: it consumes the core's 8-bit LED value and address strobe, and drives the common-enable and segment pins of the dual-digit display. It latches the value once per frame so digits never tear, inserts dead time between digits to suppress ghosting, and stretches the one-cycle address strobe so the decimal point is visible.

## Interface
- `SHOW_CYCLES`, default 64: cycles each digit is lit per frame; must be ≥1.
- `BLANK_CYCLES`, default 4: dead cycles before each digit, with all enables off; must be ≥1.
- `DP_STRETCH`, default 4096: cycles the decimal point stays asserted after a strobe; must be ≥1.
- `clk`, in, 1: the block's only clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `value`, in, 8: hex value to display; `[3:0]` goes to the low digit, `[7:4]` to the high digit.
- `strobe`, in, 1: address strobe from the core; a one-cycle pulse is enough.
- `seg`, out, 7: `{a,b,c,d,e,f,g}`, active-high, registered.
- `dp`, out, 1: decimal point, active-high, registered.
- `en`, out, 2: digit enables, active-high, one-hot or zero; `en[0]` is the low digit and `en[1]` the high digit. Registered.

## Operation
- FSM states, in order: `BLANK_LO` → `SHOW_LO` → `BLANK_HI` → `SHOW_HI` → `BLANK_LO`.
- A phase counter is sized with `$clog2` of the larger phase length.
  - It counts 0 to N-1 in each state, where N is `BLANK_CYCLES` or `SHOW_CYCLES`.
  - At N-1 it advances the state and resets to 0.
- Frame period is 2·(`SHOW_CYCLES`+`BLANK_CYCLES`) cycles.
- Frame latch: `value` is sampled into `shown` on the edge that enters `BLANK_LO`. Changes to `value` during a frame are ignored until the next frame.
- Outputs by state:
  - `BLANK_*`: `en`=00, `seg`=0, `dp`=0.
  - `SHOW_LO`: `en`=01, `seg`=glyph(`shown[3:0]`).
  - `SHOW_HI`: `en`=10, `seg`=glyph(`shown[7:4]`).
- Glyph table:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- DP stretch:
  - `strobe`=1 loads the down-counter `dp_cnt` with `DP_STRETCH`.
  - Otherwise `dp_cnt` decrements while nonzero.
  - `dp` = (`dp_cnt`≠0) during either `SHOW_*` state, on both digits.
  - A strobe that arrives while counting reloads the counter; it does not accumulate.
- Reset (async assert):
  - State goes to `BLANK_LO`; phase counter, `shown`, and `dp_cnt` go to 0.
  - `seg`=0, `dp`=0, `en`=00.
  - Reset applies immediately even mid-`SHOW`, so the display goes dark that instant.
- The first frame after reset release shows the `value` sampled when `BLANK_LO` is next entered.
  - The first pass through `BLANK_LO` after reset leaves `shown`=0.

## Timing
- All outputs change only on the `clk` edge that enters a state, so the outputs are registered off next-state.
- `en` never has both bits set. At least `BLANK_CYCLES` cycles of `en`=00 separate any change from 01 to 10 or from 10 to 01.
- Edge numbering after `rst_n` deasserts:
  - Edge `BLANK_CYCLES` enters `SHOW_LO`.
  - Edge `BLANK_CYCLES`+`SHOW_CYCLES` enters `BLANK_HI`.
  - And so on.
- `value` to display latency is at most one frame plus `BLANK_CYCLES`.
- `strobe` to `dp` latency is 1 cycle if currently in `SHOW`; otherwise it is the next `SHOW` entry, provided `dp_cnt` is still nonzero.
- The phase counter wraps cleanly; no state is ever skipped for any legal parameter values.

## Configuration
- Macro: `VSLC_SEG_LZB_EN` (leading-zero blanking).
- Defined: if `shown[7:4]`==0, `SHOW_HI` drives `en`=00, `seg`=0, `dp`=0.
  - State timing is unchanged, so brightness of the low digit is the same.
- Undefined: the high digit always shows its glyph, including "0".

## Test plan
- **Reset values:** hold `rst_n`=0 with `value`=8'hFF and `strobe`=1 → `seg`=0, `dp`=0, `en`=00 throughout.
- **Frame sequencing:** SHOW=4, BLANK=2, `value`=8'h3A, and no strobe. Expect `en` to repeat 00×2, 01×4, 00×2, 10×4 with a period of 12.
  - `seg`=1110111 while `en`=01.
  - `seg`=1111001 while `en`=10.
- **No tearing:** change `value` from 8'h12 to 8'h34 midway through `SHOW_LO`. `SHOW_HI` of that frame shows "1" (0110000); the next frame shows 4 and 3.
- **DP stretch:** DP_STRETCH=20 with a one-cycle `strobe`.
  - `dp`=1 only during `SHOW` cycles inside the following 20-cycle window; 0 after it.
  - A second strobe at cycle 10 extends the window to cycle 30.
- **Mid-show reset:** assert `rst_n`=0 asynchronously during `SHOW_HI`. `en`=00 immediately, before the next edge; after release the sequence restarts at `BLANK_LO` with `shown`=0.
- **LZB:** with `VSLC_SEG_LZB_EN` defined and `value`=8'h07, `en` never equals 10 and the low digit shows 1110000. Without the macro, the high digit shows 1111110.

Source files
------------

// File: rtl/vslc_7seg_scanner.sv
// vslc_7seg_scanner: two-digit multiplexed 7-segment scanner with frame latch, dead time and DP stretch.
// Define VSLC_SEG_LZB_EN to blank the high digit when its nibble is zero (leading-zero blanking).
module vslc_7seg_scanner #(
    parameter int SHOW_CYCLES  = 64,
    parameter int BLANK_CYCLES = 4,
    parameter int DP_STRETCH   = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] value,
    input  logic       strobe,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] en
);
    localparam int MAXN = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int PW   = (MAXN > 1) ? $clog2(MAXN) : 1;
    localparam int DW   = $clog2(DP_STRETCH + 1);

    typedef enum logic [1:0] {BLANK_LO, SHOW_LO, BLANK_HI, SHOW_HI} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [7:0]      shown_q, shown_d;
    logic [DW-1:0]   dp_cnt_q, dp_cnt_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic [1:0]      en_q, en_d;
    logic            last, show, hi;
    logic [3:0]      nib;

    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: glyph = 7'b1111110;
            4'h1: glyph = 7'b0110000;
            4'h2: glyph = 7'b1101101;
            4'h3: glyph = 7'b1111001;
            4'h4: glyph = 7'b0110011;
            4'h5: glyph = 7'b1011011;
            4'h6: glyph = 7'b1011111;
            4'h7: glyph = 7'b1110000;
            4'h8: glyph = 7'b1111111;
            4'h9: glyph = 7'b1111011;
            4'hA: glyph = 7'b1110111;
            4'hB: glyph = 7'b0011111;
            4'hC: glyph = 7'b1001110;
            4'hD: glyph = 7'b0111101;
            4'hE: glyph = 7'b1001111;
            default: glyph = 7'b1000111;
        endcase
    endfunction

    always_comb begin
        last     = (state_q == SHOW_LO || state_q == SHOW_HI) ? (phase_q == PW'(SHOW_CYCLES - 1))
                                                              : (phase_q == PW'(BLANK_CYCLES - 1));
        phase_d  = last ? '0 : PW'(phase_q + 1'b1);
        state_d  = last ? state_t'(state_q + 2'd1) : state_q;
        // the frame's value is captured only on the wrap back into BLANK_LO
        shown_d  = (last && state_q == SHOW_HI) ? value : shown_q;
        dp_cnt_d = strobe ? DW'(DP_STRETCH) : (dp_cnt_q != '0 ? dp_cnt_q - 1'b1 : dp_cnt_q);
        hi       = (state_d == SHOW_HI);
        nib      = hi ? shown_q[7:4] : shown_q[3:0];
`ifdef VSLC_SEG_LZB_EN
        show     = (state_d == SHOW_LO) || (hi && shown_q[7:4] != 4'h0);
`else
        show     = (state_d == SHOW_LO) || hi;
`endif
        en_d     = show ? (hi ? 2'b10 : 2'b01) : 2'b00;
        seg_d    = show ? glyph(nib) : 7'b0;
        dp_d     = show && (dp_cnt_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BLANK_LO;
            phase_q  <= '0;
            shown_q  <= '0;
            dp_cnt_q <= '0;
            seg_q    <= '0;
            dp_q     <= 1'b0;
            en_q     <= 2'b00;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            shown_q  <= shown_d;
            dp_cnt_q <= dp_cnt_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            en_q     <= en_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign en  = en_q;
endmodule

// File: tb/tb_vslc_7seg_scanner.sv
// tb_vslc_7seg_scanner: randomized scoreboard bench; a time-based frame model predicts en/seg/dp every cycle.
module tb_vslc_7seg_scanner;
    localparam int S = 4, B = 2, D = 20, P = 2 * (S + B);

    logic       clk = 1'b0, rst_n = 1'b0, strobe = 1'b1;
    logic [7:0] value = 8'hFF;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] en;

    vslc_7seg_scanner #(.SHOW_CYCLES(S), .BLANK_CYCLES(B), .DP_STRETCH(D)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .strobe(strobe), .seg(seg), .dp(dp), .en(en)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] en;
        logic [6:0] seg;
        logic       dp;
    } obs_t;

    obs_t       exp_q[$];
    int         vectors = 0, errors = 0;
    logic [6:0] glyph_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                   7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                   7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                   7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    // reference: position in frame from edges since reset; dp from age of last strobe
    initial begin : model
        int t, ls, pos;
        bit have, lo, hi;
        logic [7:0] shown;
        obs_t e;
        t = 0; ls = 0; have = 0; shown = '0;
        forever begin
            @(posedge clk);
            e = '0;
            if (!rst_n) begin
                t = 0; have = 0; shown = '0;
            end else begin
                t++;
                if (t % P == 0) shown = value;
                if (strobe) begin ls = t; have = 1; end
                pos = t % P;
                lo  = pos >= B && pos < B + S;
                hi  = pos >= 2 * B + S;
`ifdef VSLC_SEG_LZB_EN
                if (shown[7:4] == 4'h0) hi = 0;
`endif
                if (lo) begin e.en = 2'b01; e.seg = glyph_tab[shown[3:0]]; end
                if (hi) begin e.en = 2'b10; e.seg = glyph_tab[shown[7:4]]; end
                e.dp = (lo || hi) && have && (t - ls < D);
            end
            exp_q.push_back(e);
        end
    end

    initial begin : monitor
        obs_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if ({en, seg, dp} !== e) begin
                    errors++;
                    $display("FAIL outputs @%0t: got en=%b seg=%b dp=%b, expected en=%b seg=%b dp=%b",
                             $time, en, seg, dp, e.en, e.seg, e.dp);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic random_run(input int n, input int strobe_odds);
        repeat (n) begin
            @(negedge clk); #1;
            if ($urandom_range(0, 19) == 0) value = 8'($urandom);
            strobe = ($urandom_range(0, strobe_odds) == 0);
        end
        @(negedge clk); #1;
        strobe = 1'b0;
    endtask

    initial begin : stim
        int n;
        // reset held with busy inputs
        cycles(6);
        strobe = 1'b0; value = 8'h3A;
        rst_n = 1'b1;
        cycles(4 * P);
        // no tearing: change value mid SHOW_LO
        value = 8'h12;
        cycles(P);
        n = 0;
        do begin @(negedge clk); n++; end while (en !== 2'b01 && n < 3 * P);
        #1 cycles(1);
        value = 8'h34;
        cycles(3 * P);
        // dp stretch with a reloading second strobe
        strobe = 1'b1; cycles(1); strobe = 1'b0;
        cycles(9);
        strobe = 1'b1; cycles(1); strobe = 1'b0;
        cycles(4 * P);
        // leading-zero case
        value = 8'h07;
        cycles(3 * P);
        // mid-show asynchronous reset
        value = 8'h5C;
        cycles(2 * P);
        n = 0;
        do begin @(negedge clk); n++; end while (en !== 2'b10 && n < 3 * P);
        if (en !== 2'b10) begin
            vectors++; errors++;
            $display("FAIL wait_show_hi: en=%b after %0d cycles, required 10", en, n);
        end
        #1 rst_n = 1'b0;
        #1 vectors++;
        if ({en, seg, dp} !== 10'b0) begin
            errors++;
            $display("FAIL async_reset: en=%b seg=%b dp=%b, required all zero", en, seg, dp);
        end
        cycles(3);
        rst_n = 1'b1;
        cycles(2 * P);
        random_run(600, 40);
        cycles(3 * P);
        random_run(200, 4);
        cycles(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
